halt_checker: RTL

Synthesizable, parametrised halt monitor for SoC-level simulation and FPGA bring-up. It counts cycles after reset release, captures one or more result words on the first `halt` assertion, and enforces three halt-integrity rules: halt in time, halt stays high, captured words stay stable. After a configurable settle window it reports the outcome through registered `done`/`err` flags, the captured words and the cycle counts. It sits beside `dut_soc`, taking the `halt` output and the word channels.

---
 rtl/halt_checker_if.sv | 28 ++
 rtl/halt_checker.sv | 131 +++++++++++++
 2 files changed

// File: rtl/halt_checker_if.sv
// Halt-monitor bus: the halt/word channels observed from the SoC and the
// result flags/words reported by the checker.
//   master : drives halt and words, observes the results (SoC side / bench)
//   slave  : the checker; samples halt/words, drives the results
interface halt_checker_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned CNT_W  = 32
);
  logic                       halt;
  logic [NUM_CH*WORD_W-1:0]   words;
  logic                       done;
  logic                       err;
  logic [1:0]                 errCode;
  logic [NUM_CH*WORD_W-1:0]   capWords;
  logic [CNT_W-1:0]           haltCnt;
  logic [CNT_W-1:0]           capCnt;

  modport master (
    output halt, words,
    input  done, err, errCode, capWords, haltCnt, capCnt
  );

  modport slave (
    input  halt, words,
    output done, err, errCode, capWords, haltCnt, capCnt
  );
endinterface

// File: rtl/halt_checker.sv
// Halt monitor: counts cycles after reset release, captures the word channels
// on the first halt, checks halt timeliness/stability and word stability, and
// reports done/err after a settle window. All outputs are registered.
// Ports:
//   clk  - system clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - halt_checker_if.slave: halt/words in; done, err, errCode,
//          capWords, haltCnt, capCnt out
module halt_checker #(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned NUM_CH   = 1,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 10000,
  parameter int unsigned SETTLE   = 5,
  parameter bit          CHECK_EN = 1'b1
) (
  input logic            clk,
  input logic            rstn,
  halt_checker_if.slave  bus
);

  localparam int unsigned DataW = NUM_CH * WORD_W;

  // The counter must be able to reach TIMEOUT+1 for the timeout to fire.
  localparam longint unsigned CntMax = (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                     : ((64'd1 << CNT_W) - 64'd1);
  if (64'(TIMEOUT) >= CntMax) begin : gen_cnt_w_too_small
    $error("halt_checker: CNT_W too small to count past TIMEOUT");
  end
  if (NUM_CH < 1) begin : gen_num_ch_zero
    $error("halt_checker: NUM_CH must be at least 1");
  end

  typedef enum logic [1:0] {StRun, StHalted, StDone, StError} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [DataW-1:0]   cap_words_q, cap_words_d;
  logic [CNT_W-1:0]   halt_cnt_q, halt_cnt_d;
  logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;

  always_comb begin
    // Saturating post-increment value; every decision on this edge uses it.
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    cap_words_d = cap_words_q;
    halt_cnt_d  = halt_cnt_q;
    cap_cnt_d   = cap_cnt_q;

    unique case (state_q)
      StRun: begin
        cnt_d = cnt_inc;
        // Halt wins over a timeout on the same edge.
        if (bus.halt) begin
          cap_words_d = bus.words;
          halt_cnt_d  = cnt_inc;
          if (SETTLE == 0) begin
            state_d   = StDone;
            done_d    = 1'b1;
            cap_cnt_d = cnt_inc;
          end else begin
            state_d   = StHalted;
          end
        end else if (CHECK_EN && (cnt_inc > CNT_W'(TIMEOUT))) begin
          state_d    = StError;
          err_d      = 1'b1;
          err_code_d = 2'd1;
          cap_cnt_d  = cnt_inc;
        end
      end
      StHalted: begin
        cnt_d = cnt_inc;
        if (CHECK_EN && !bus.halt) begin
          state_d    = StError;
          err_d      = 1'b1;
          err_code_d = 2'd2;
          cap_cnt_d  = cnt_inc;
        end else if (CHECK_EN && (bus.words != cap_words_q)) begin
          state_d    = StError;
          err_d      = 1'b1;
          err_code_d = 2'd3;
          cap_cnt_d  = cnt_inc;
        end else if ((cnt_inc - halt_cnt_q) == CNT_W'(SETTLE)) begin
          state_d   = StDone;
          done_d    = 1'b1;
          cap_cnt_d = cnt_inc;
        end
      end
      // Terminal: counter frozen, inputs ignored.
      StDone, StError: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      cap_words_q <= '0;
      halt_cnt_q  <= '0;
      cap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cap_words_q <= cap_words_d;
      halt_cnt_q  <= halt_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.errCode  = err_code_q;
  assign bus.capWords = cap_words_q;
  assign bus.haltCnt  = halt_cnt_q;
  assign bus.capCnt   = cap_cnt_q;

endmodule
